// File: rtl/fp_round_pack_if.sv
// Handshake and payload bundle between the binary64 adder datapath and the
// normalize/round/pack stage.
interface fp_round_pack_if;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] es;
  logic [56:0] fs;
  logic        ss;
  logic [1:0]  fls;
  logic [1:0]  rm;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] fp;
  logic        ovf;
  logic        unf;
  logic        inx;

  modport slave (
    input  in_valid, es, fs, ss, fls, rm, out_ready,
    output in_ready, out_valid, fp, ovf, unf, inx
  );

  modport master (
    output in_valid, es, fs, ss, fls, rm, out_ready,
    input  in_ready, out_valid, fp, ovf, unf, inx
  );
endinterface

// File: rtl/fp_round_pack.sv
// Binary64 post-adder stage: bit-serial normalize, round to 53 bits under a
// selectable mode, pack into an IEEE-754 word with overflow/underflow/inexact.
module fp_round_pack (
  input  logic         clk,
  input  logic         rst_n,
  fp_round_pack_if.slave bus
);

  localparam int unsigned EW = 12;
  localparam int unsigned FW = 57;
  localparam int unsigned MW = 53;

  localparam logic [1:0] CLS_FIN  = 2'b00;
  localparam logic [1:0] CLS_ZERO = 2'b01;
  localparam logic [1:0] CLS_INF  = 2'b10;
  localparam logic [1:0] CLS_NAN  = 2'b11;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_PI  = 2'b10;
  localparam logic [1:0] RM_NI  = 2'b11;

  localparam logic [EW-1:0] E_MAX = EW'(2047);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    NORM  = 3'd1,
    ROUND = 3'd2,
    PACK  = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [EW-1:0] e_q, e_d;
  logic [FW-1:0] f_q, f_d;
  logic          s_q, s_d;
  logic [1:0]    cls_q, cls_d;
  logic [1:0]    mode_q, mode_d;
  logic          inexact_q, inexact_d;
  logic [63:0]   fp_q, fp_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          inx_q, inx_d;

  logic          rnd_inexact;
  logic          rnd_inc;
  logic [MW:0]   rnd_sum;
  logic          ovf_to_inf;

  // Rounding increment and 53-bit significand sum, evaluated from the current f.
  always_comb begin
    rnd_inexact = |f_q[2:0];
    rnd_inc     = 1'b0;
    case (mode_q)
      RM_RNE:  rnd_inc = f_q[2] & (f_q[1] | f_q[0] | f_q[3]);
      RM_RTZ:  rnd_inc = 1'b0;
      RM_PI:   rnd_inc = ~s_q & rnd_inexact;
      RM_NI:   rnd_inc = s_q & rnd_inexact;
      default: rnd_inc = 1'b0;
    endcase
    rnd_sum    = {1'b0, f_q[55:3]} + (MW+1)'(rnd_inc);
    ovf_to_inf = (mode_q == RM_RNE) | ((mode_q == RM_PI) & ~s_q) |
                 ((mode_q == RM_NI) & s_q);
  end

  always_comb begin
    state_d   = state_q;
    e_d       = e_q;
    f_d       = f_q;
    s_d       = s_q;
    cls_d     = cls_q;
    mode_d    = mode_q;
    inexact_d = inexact_q;
    fp_d      = fp_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    inx_d     = inx_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          e_d     = {1'b0, bus.es};
          f_d     = bus.fs;
          s_d     = bus.ss;
          cls_d   = bus.fls;
          mode_d  = bus.rm;
          state_d = (bus.fls == CLS_FIN) ? NORM : PACK;
        end
      end

      NORM: begin
        if (f_q == '0) begin
          cls_d   = CLS_ZERO;
          state_d = PACK;
        end else if (f_q[56]) begin
          f_d = {1'b0, f_q[56:2], f_q[1] | f_q[0]};
          e_d = e_q + EW'(1);
        end else if (e_q == '0) begin
          f_d = {1'b0, f_q[56:2], f_q[1] | f_q[0]};
          e_d = EW'(1);
        end else if (!f_q[55] && (e_q > EW'(1))) begin
          f_d = {f_q[55:0], 1'b0};
          e_d = e_q - EW'(1);
        end else begin
          state_d = ROUND;
        end
      end

      ROUND: begin
        inexact_d = rnd_inexact;
        if (rnd_sum[MW]) begin
          f_d = {2'b01, 52'b0, 3'b000};
          e_d = e_q + EW'(1);
        end else begin
          f_d = {1'b0, rnd_sum[MW-1:0], 3'b000};
        end
        state_d = PACK;
      end

      PACK: begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = 1'b0;
        case (cls_q)
          CLS_NAN:  fp_d = 64'h7FF8_0000_0000_0000;
          CLS_INF:  fp_d = {s_q, 11'h7FF, 52'b0};
          CLS_ZERO: fp_d = {s_q, 63'b0};
          default: begin
            if (e_q >= E_MAX) begin
              ovf_d = 1'b1;
              inx_d = 1'b1;
              fp_d  = ovf_to_inf ? {s_q, 11'h7FF, 52'b0}
                                 : {s_q, 11'h7FE, {52{1'b1}}};
            end else begin
              fp_d  = {s_q, (f_q[55] ? e_q[10:0] : 11'b0), f_q[54:3]};
              inx_d = inexact_q;
              unf_d = ~f_q[55] & inexact_q;
            end
          end
        endcase
        state_d = OUT;
      end

      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      e_q       <= '0;
      f_q       <= '0;
      s_q       <= 1'b0;
      cls_q     <= '0;
      mode_q    <= '0;
      inexact_q <= 1'b0;
      fp_q      <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      inx_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      e_q       <= e_d;
      f_q       <= f_d;
      s_q       <= s_d;
      cls_q     <= cls_d;
      mode_q    <= mode_d;
      inexact_q <= inexact_d;
      fp_q      <= fp_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      inx_q     <= inx_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == OUT);
  assign bus.fp        = fp_q;
  assign bus.ovf       = ovf_q;
  assign bus.unf       = unf_q;
  assign bus.inx       = inx_q;

endmodule

// File: doc/fp_round_pack.md
# fp_round_pack

Post-adder normalize/round/pack stage for double precision. It consumes the adder's raw result (`es`, `fs`, `ss`, `fls`) through a valid/ready handshake and normalizes the significand one bit per cycle. It then rounds to 53 bits under a selectable rounding mode and emits a packed IEEE-754 binary64 word with exception flags. It sits directly downstream of the adder datapath.

## Interface
- No parameters; all widths are fixed to binary64.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: high only in IDLE.
- `es` in 11: biased exponent.
- `fs` in 57: significand. `fs[56]` is the carry bit, `fs[55]` is the hidden bit, `fs[54:3]` is the fraction, `fs[2]`=G, `fs[1]`=R, `fs[0]`=S (sticky).
- `ss` in 1: sign.
- `fls` in 2: class. 00=finite, 01=zero, 10=infinity, 11=NaN.
- `rm` in 2: rounding mode. 00=RNE, 01=RTZ, 10=toward +inf, 11=toward -inf.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts.
- `fp` out 64: packed result.
- `ovf`, `unf`, `inx` out 1 each: overflow, underflow, inexact.

## Operation
- **States:** IDLE, NORM, ROUND, PACK, OUT.
- **Internal registers:** e (12-bit unsigned), f (57-bit), s, cls, mode.
- **IDLE:**
  - On `in_valid & in_ready`, capture `es`/`fs`/`ss`/`fls`/`rm`.
  - If `fls`=00, go to NORM. Otherwise go to PACK.
- **NORM:** one action per cycle, in this priority:
  1. f==0: set cls=zero, go to PACK.
  2. f[56]=1: shift f right 1 with f[0] |= dropped bit, e+=1, stay in NORM.
  3. e==0: shift f right 1 with sticky, e=1, stay in NORM.
  4. f[55]=0 and e>1: shift f left 1, e-=1, stay in NORM.
  5. Otherwise go to ROUND. This covers f[55]=1, and also e==1 with f[55]=0, which is subnormal.
- **ROUND:**
  - Rounding bits: lsb=f[3], g=f[2], r=f[1], st=f[0]. inexact = g|r|st.
  - Increment:
    - RNE: g&(r|st|lsb).
    - RTZ: 0.
    - +inf: ~s & inexact.
    - -inf: s & inexact.
  - Add the increment to f[55:3] (53-bit). On carry-out, set f[55:3]=1<<52 and e+=1.
  - Clear f[2:0] and go to PACK.
- **PACK** (writes `fp` and the flags):
  - **NaN:** `fp`=0x7FF8000000000000, flags 0.
  - **Infinity:** `fp`={s,0x7FF,52'b0}, flags 0.
  - **Zero:** `fp`={s,63'b0}, flags 0.
  - **Finite with e>=2047:** overflow. Set ovf=1, inx=1.
    - Infinity when RNE, when +inf with s=0, or when -inf with s=1.
    - Otherwise max finite {s,0x7FE,52'hFFFFFFFFFFFFF}.
  - **Finite, other:**
    - Exponent field = f[55] ? e[10:0] : 0; fraction = f[54:3].
    - inx = inexact; unf = (f[55]==0) & inexact.
    - A subnormal that rounds into f[55] packs exponent 1.
  - Go to OUT.
- **OUT:** `out_valid`=1; `fp` and the flags are held stable. On `out_ready`, go to IDLE.
- Input is not accepted while OUT is pending; there is no overlap of OUT and capture.
- **Reset (any state, including mid-NORM):**
  - State goes to IDLE and all registers clear.
  - `out_valid`=0, `fp`=0, `ovf`=`unf`=`inx`=0; the in-flight operand is discarded.
  - `in_ready`=1 (state is IDLE).

## Timing
- Capture happens at edge 0.
- **Finite input:** k NORM action cycles (k = left shifts + right shifts), then 1 NORM cycle into ROUND, 1 ROUND cycle, 1 PACK cycle.
  - `out_valid` rises after edge 3+k.
  - Already-normalized input: after edge 3.
  - Carry input (f[56]=1): after edge 4.
- **Special class** (zero, infinity, NaN via `fls`): `out_valid` rises after edge 1.
- **f==0 found in NORM:** `out_valid` rises after edge 2.
- Worst case is 55 left shifts, giving latency 58.
- `in_ready` is combinational from the state register: high exactly in IDLE.
- The next capture is possible on the edge after the `out_valid & out_ready` edge.
- A `out_valid & out_ready` handshake with `in_valid` held high gives one IDLE cycle between results.

## Test plan
- **Normalized input:** es=0x3FF, fs[55:54]=11, rest 0, RNE.
  - `fp`=0x3FF8000000000000, `out_valid` 3 cycles after accept, flags 0.
- **Carry input:** es=0x3FF, fs=1<<56.
  - `fp`=0x4000000000000000, latency 4.
- **Left shift:** es=0x400, fs=1<<53 (2 left shifts).
  - `fp`=0x3FE0000000000000, latency 5.
- **Tie to even:** es=0x3FF, f[55]=1, f[3]=1, G=1, R=S=0.
  - RNE gives 0x3FF0000000000002 with inx=1.
  - Same input with f[3]=0 under RNE gives 0x3FF0000000000000 with inx=1.
  - Same input under RTZ gives 0x3FF0000000000001.
- **Overflow:** es=0x7FE, f[55:3] all ones, G=1, s=0.
  - RNE gives 0x7FF0000000000000 with ovf=inx=1.
  - RTZ gives 0x7FEFFFFFFFFFFFFF.
- **Specials, backpressure, reset:**
  - `fls`=11 gives 0x7FF8000000000000 at latency 1.
  - Holding `out_ready`=0 for 5 cycles keeps `fp` stable and `in_ready`=0.
  - Asserting `rst_n`=0 mid-NORM forces `out_valid`=0 and `fp`=0 immediately; the next input then processes correctly.
